cfb_enc: RTL and testbench
==========================

# cfb_enc

Single-block DES encryptor in 64-bit Cipher Feedback (CFB-64) mode: ciphertext = DES_K(iv) XOR message. The block takes one 64-bit message word per request and computes the DES rounds iteratively, one round per clock. Chaining is done by the caller, which feeds the previous ciphertext back as the next `iv`. It sits between the message buffer and the output writer in the DES mode-of-operation datapath.

## Interface
- No parameters; block size and key width are fixed at 64 bits and the round count at 16.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `start`  in  1  Request strobe. Sampled only while idle.
- `message`  in  [64:1]  Plaintext block. Bit 64 is DES bit 1 (MSB).
- `key`  in  [64:1]  DES key including parity bits. Parity bits are ignored.
- `iv`  in  [64:1]  Feedback register value to encrypt.
- `ciphertext`  out  [64:1]  Registered result; holds until the next completion.
- `busy`  out  1  High from the accepting edge through the completion edge.
- `done`  out  1  One-cycle pulse when `ciphertext` is updated.

## Operation
- Bit numbering follows FIPS 46-3 throughout: vector bit 64 is standard bit 1. All permutations use the standard tables: IP, FP (IP⁻¹), E, P, PC-1, PC-2.
- Accept (idle and `start`=1):
  - Capture `message` into an internal register.
  - Apply PC-1 to `key`, giving C0/D0 (28 bits each).
  - Apply IP to `iv`, giving L0/R0.
  - Clear the round counter.
- Round i (1..16), one per clock:
  - Rotate C and D left by 1 for i ∈ {1,2,9,16}, else by 2.
  - Ki = PC-2(C‖D).
  - f = P(S(E(R) XOR Ki)), with S-boxes S1..S8 applied to 6-bit groups MSB-first. Row = outer bits, column = inner 4 bits.
  - L ← R; R ← L XOR f.
- Completion:
  - `ciphertext` ← FP(R16‖L16) XOR captured message. Note the swap: R16 comes first.
  - `done`=1 for one cycle; return to idle.
- S-boxes are implemented as constant lookup (ROM, case statement or packed constant). No memory macros.
- Inputs are read only at the accept edge. Changes to `message`, `key` or `iv` while busy have no effect.
- `start` while busy is ignored; it is not queued.
- States:
  - IDLE → ROUND on `start`.
  - ROUND stays in ROUND while counter < 16.
  - After round 16, ROUND → FINISH.
  - FINISH → IDLE unconditionally.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
  - E1..E16 execute rounds 1..16.
  - E17 writes `ciphertext` and sets `done`.
  - `done` is high for exactly the cycle after E17; `busy` is low after E17.
- Latency is 17 clocks from the accepting edge to valid output. Throughput is one block per 18 clocks when `start` is held high, since the block re-accepts at the first IDLE edge after E17.
- A new request may be accepted on the edge right after `done` deasserts. That same edge may sample `iv` = the just-produced `ciphertext`.
- Reset values:
  - `ciphertext`=64'h0, `done`=0, `busy`=0, state=IDLE.
  - All internal registers (counter, C/D, L/R, message) cleared.
- `rst` takes priority over everything, including mid-computation and a simultaneous `start`. An aborted operation never asserts `done`.
- No combinational path from inputs to outputs.

## Test plan
- Known answer:
  - Stimulus: key=64'h133457799BBCDFF1, iv=64'h0123456789ABCDEF, message=0, pulse `start`.
  - Response: 17 clocks later `done`=1 and `ciphertext`=64'h85E813540F0AB405.
- XOR path:
  - Stimulus: same key and iv, message=64'hFFFFFFFFFFFFFFFF.
  - Response: `ciphertext`=64'h7A17ECABF0F54BFA.
- Zero key:
  - Stimulus: key=0, iv=0, message=0.
  - Response: `ciphertext`=64'h8CA64DE9C1B123A7.
- Chaining:
  - Stimulus: run 1000 blocks from a message file, feeding each `ciphertext` back as the next `iv`.
  - Response: every output matches a software DES-CFB-64 reference.
  - Also change `key` and `message` mid-operation: no effect on the output.
- Control:
  - Stimulus: `start` asserted while busy; separately, assert `rst` at round 8.
  - Response: the busy-time start is ignored (exactly one `done`, at the original E17). The reset run gives `busy`=0, `ciphertext`=0, no `done`, and the next request completes correctly.
- Back-to-back:
  - Stimulus: `start` held high for 3 requests.
  - Response: `done` pulses spaced 18 clocks apart, each with the correct result.

Source files
------------

// File: rtl/cfb_enc.sv
// DES encryptor in CFB-64 mode: ciphertext = DES_K(iv) ^ message.
// Rounds run iteratively, one per clock; the caller chains iv externally.
module cfb_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [64:1] message,
  input  logic [64:1] key,
  input  logic [64:1] iv,
  output logic [64:1] ciphertext,
  output logic        busy,
  output logic        done
);

  // Standard tables; entries are FIPS bit numbers (1 = MSB = vector bit 64).
  localparam int ip_tab [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int fp_tab [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int e_tab [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int p_tab [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int pc1_tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // One 256-bit constant per S-box; nibble n (leftmost first) is entry row*16+col.
  localparam logic [255:0] sbox_rom [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [64:1] do_ip(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 1; j <= 64; j++) y[65-j] = x[65-ip_tab[j-1]];
    return y;
  endfunction

  function automatic logic [64:1] do_fp(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 1; j <= 64; j++) y[65-j] = x[65-fp_tab[j-1]];
    return y;
  endfunction

  function automatic logic [56:1] do_pc1(input logic [64:1] x);
    logic [56:1] y;
    y = '0;
    for (int j = 1; j <= 56; j++) y[57-j] = x[65-pc1_tab[j-1]];
    return y;
  endfunction

  function automatic logic [48:1] do_pc2(input logic [56:1] x);
    logic [48:1] y;
    y = '0;
    for (int j = 1; j <= 48; j++) y[49-j] = x[57-pc2_tab[j-1]];
    return y;
  endfunction

  function automatic logic [48:1] do_e(input logic [32:1] x);
    logic [48:1] y;
    y = '0;
    for (int j = 1; j <= 48; j++) y[49-j] = x[33-e_tab[j-1]];
    return y;
  endfunction

  function automatic logic [32:1] do_p(input logic [32:1] x);
    logic [32:1] y;
    y = '0;
    for (int j = 1; j <= 32; j++) y[33-j] = x[33-p_tab[j-1]];
    return y;
  endfunction

  // Row comes from the outer bits of each 6-bit group, column from the inner four.
  function automatic logic [32:1] do_sbox(input logic [48:1] x);
    logic [32:1] y;
    logic [6:1]  g;
    int          idx;
    y = '0;
    for (int s = 0; s < 8; s++) begin
      g   = x[48-6*s -: 6];
      idx = int'({g[6], g[1], g[5:2]});
      y[32-4*s -: 4] = sbox_rom[s][255-4*idx -: 4];
    end
    return y;
  endfunction

  typedef enum logic [1:0] {st_idle, st_round, st_finish} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;    // rounds completed so far
  logic [28:1] c_q, d_q;
  logic [32:1] l_q, r_q;
  logic [64:1] msg_q;

  logic        shift1;
  logic [28:1] c_rot, d_rot;
  logic [48:1] subkey;
  logic [32:1] f_out;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:   if (start) state_nxt = st_round;
      st_round:  if (cnt == 5'd15) state_nxt = st_finish;
      st_finish: state_nxt = st_idle;
      default:   state_nxt = st_idle;
    endcase
  end

  // Round i = cnt+1; rounds 1, 2, 9 and 16 rotate by one, all others by two.
  always_comb begin
    shift1 = (cnt == 5'd0) || (cnt == 5'd1) || (cnt == 5'd8) || (cnt == 5'd15);
    if (shift1) begin
      c_rot = {c_q[27:1], c_q[28]};
      d_rot = {d_q[27:1], d_q[28]};
    end else begin
      c_rot = {c_q[26:1], c_q[28:27]};
      d_rot = {d_q[26:1], d_q[28:27]};
    end
    subkey = do_pc2({c_rot, d_rot});
    f_out  = do_p(do_sbox(do_e(r_q) ^ subkey));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= st_idle;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      l_q        <= '0;
      r_q        <= '0;
      msg_q      <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        st_idle: begin
          if (start) begin
            msg_q      <= message;
            {c_q, d_q} <= do_pc1(key);
            {l_q, r_q} <= do_ip(iv);
            cnt        <= '0;
          end
        end
        st_round: begin
          c_q <= c_rot;
          d_q <= d_rot;
          l_q <= r_q;
          r_q <= l_q ^ f_out;
          cnt <= cnt + 5'd1;
        end
        st_finish: begin
          // Pre-output is R16 || L16: the final halves are swapped before FP.
          ciphertext <= do_fp({r_q, l_q}) ^ msg_q;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != st_idle);

endmodule

// File: tb/tb_cfb_enc.sv
// Bench for cfb_enc: software DES-CFB model with a cycle-count timing model,
// compared against the DUT every cycle, plus directed known-answer vectors.
module tb_cfb_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [64:1] message = '0;
  logic [64:1] key = '0;
  logic [64:1] iv = '0;
  logic [64:1] ciphertext;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  localparam logic [63:0] kat_key = 64'h133457799BBCDFF1;
  localparam logic [63:0] kat_iv  = 64'h0123456789ABCDEF;

  always #5 clk = ~clk;

  cfb_enc dut (
    .clk(clk), .rst(rst), .start(start), .message(message), .key(key), .iv(iv),
    .ciphertext(ciphertext), .busy(busy), .done(done)
  );

  localparam int ip_t [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int p_t [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [255:0] sbox_t [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Software DES; E is generated arithmetically and FP is applied as the inverse of IP.
  function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] pt);
    logic [63:0] perm, pre, ct;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] kk, ex;
    logic [31:0] l, r, t, so, fo;
    logic [5:0]  six;
    int          idx, src, sh;
    for (int j = 1; j <= 64; j++) perm[64-j] = pt[64-ip_t[j-1]];
    l = perm[63:32];
    r = perm[31:0];
    for (int j = 1; j <= 56; j++) cd[56-j] = k[64-pc1_t[j-1]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rnd = 1; rnd <= 16; rnd++) begin
      sh = (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 1; j <= 48; j++) kk[48-j] = cd[56-pc2_t[j-1]];
      for (int j = 1; j <= 48; j++) begin
        src = ((4*((j-1)/6) + (j-1)%6 - 1 + 32) % 32) + 1;
        ex[48-j] = r[32-src];
      end
      ex = ex ^ kk;
      for (int s = 0; s < 8; s++) begin
        six = ex[47-6*s -: 6];
        idx = {six[5], six[0]} * 16 + six[4:1];
        so[31-4*s -: 4] = sbox_t[s][255-4*idx -: 4];
      end
      for (int j = 1; j <= 32; j++) fo[32-j] = so[32-p_t[j-1]];
      t = r;
      r = l ^ fo;
      l = t;
    end
    pre = {r, l};
    for (int j = 1; j <= 64; j++) ct[64-ip_t[j-1]] = pre[64-j];
    return ct;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timing model: a request seen while idle completes 17 edges later.
  int          m_count = 0;
  logic [63:0] m_pend  = '0;
  logic [63:0] m_ct    = '0;
  logic        m_done  = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_count <= 0;
      m_ct    <= '0;
      m_done  <= 1'b0;
    end else if (m_count == 0) begin
      m_done <= 1'b0;
      if (start) begin
        m_pend  <= des_model(key, iv) ^ message;
        m_count <= 17;
      end
    end else begin
      m_count <= m_count - 1;
      m_done  <= (m_count == 1);
      if (m_count == 1) m_ct <= m_pend;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_count != 0));
      check("done", 64'(done), 64'(m_done));
      check("ciphertext", ciphertext, m_ct);
    end
  end

  // mode 1: scramble inputs mid-run; mode 2: pulse start while busy.
  task automatic run_block(input logic [63:0] k, input logic [63:0] v, input logic [63:0] m,
                           input int mode, output int lat);
    @(negedge clk);
    key = k; iv = v; message = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (mode == 1 && lat == 6) begin
        key = {$urandom, $urandom}; iv = {$urandom, $urandom}; message = {$urandom, $urandom};
      end
      if (mode == 2 && lat == 5) start = 1'b1;
      if (mode == 2 && lat == 6) start = 1'b0;
      if (done) break;
    end
    check("latency", 64'(lat), 64'd17);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  initial begin
    int          lat, n;
    int          d_cyc [3];
    logic [63:0] sw_iv, exp_ct, msg, k0;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ct", ciphertext, 64'h0);
    check("model_kat", des_model(kat_key, kat_iv), 64'h85E813540F0AB405);
    check("model_zero", des_model(64'h0, 64'h0), 64'h8CA64DE9C1B123A7);
    @(negedge clk);
    rst = 1'b0;

    run_block(kat_key, kat_iv, 64'h0, 0, lat);
    check("kat_ct", ciphertext, 64'h85E813540F0AB405);
    run_block(kat_key, kat_iv, 64'hFFFFFFFFFFFFFFFF, 0, lat);
    check("xor_ct", ciphertext, 64'h7A17ECABF0F54BFA);
    run_block(64'h0, 64'h0, 64'h0, 0, lat);
    check("zero_key_ct", ciphertext, 64'h8CA64DE9C1B123A7);

    // Start pulses while busy must neither disturb nor queue a request.
    run_block(kat_key, kat_iv, 64'h0, 2, lat);
    check("busy_start_ct", ciphertext, 64'h85E813540F0AB405);
    count_dones(25, n);
    check("busy_start_no_extra_done", 64'(n), 64'd0);

    // Abort after round 8.
    @(negedge clk);
    key = kat_key; iv = kat_iv; message = 64'h0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ct", ciphertext, 64'h0);
    count_dones(25, n);
    check("abort_no_done", 64'(n), 64'd0);
    run_block(kat_key, kat_iv, 64'hFFFFFFFFFFFFFFFF, 0, lat);
    check("after_abort_ct", ciphertext, 64'h7A17ECABF0F54BFA);

    // Back-to-back with start held; each result is fed back as the next iv.
    @(negedge clk);
    key = kat_key; iv = kat_iv; message = 64'h0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (n < 40) begin
        @(posedge clk);
        n++;
        #1;
        if (done) break;
      end
      d_cyc[i] = cyc;
      if (i == 0) check("b2b_first_ct", ciphertext, 64'h85E813540F0AB405);
      if (i < 2) iv = ciphertext;
      else start = 1'b0;
    end
    check("b2b_gap1", 64'(d_cyc[1] - d_cyc[0]), 64'd18);
    check("b2b_gap2", 64'(d_cyc[2] - d_cyc[1]), 64'd18);
    count_dones(25, n);
    check("b2b_no_fourth", 64'(n), 64'd0);

    // 1000-block CFB chain against the software reference.
    k0    = 64'h0E329232EA6D0D73;
    sw_iv = 64'hA5A5F00D12345678;
    for (int i = 0; i < 1000; i++) begin
      msg    = {$urandom, $urandom};
      exp_ct = des_model(k0, sw_iv) ^ msg;
      run_block(k0, (i == 0) ? sw_iv : ciphertext, msg, (i % 7 == 3) ? 1 : 0, lat);
      check("chain_ct", ciphertext, exp_ct);
      sw_iv = exp_ct;
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
